uart_rx_8n1: RTL
================

# uart_rx_8n1

Asynchronous serial receiver: 8 data bits, LSB first, no parity, one stop bit (8N1), oversampled by the system clock. Sits directly upstream of the byte loopback/consumer stage. Drives a one-cycle byte-ready strobe plus a byte that stays stable until the next accepted frame. Also flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 868 — system clocks per serial bit (100 MHz / 115200). Legal range ≥ 4.
- `i_clk`  input  1  system clock, all logic on rising edge
- `i_rst_n`  input  1  asynchronous, active-low reset
- `i_rx`  input  1  serial line, asynchronous to `i_clk`, idle high
- `o_rx_byte_rdy`  output  1  one-cycle strobe: `o_rx_byte` holds a newly accepted byte
- `o_rx_byte`  output  8  last accepted byte, held until the next accepted frame
- `o_frame_err`  output  1  one-cycle strobe: stop bit sampled low
- `o_busy`  output  1  high whenever the state is not IDLE

## Operation
- **Input synchronizer:** `i_rx` passes through 2 flops. Both flops reset to 1. All decisions use the second flop, `rx_s`.
- **Counters:**
  - Bit-time counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - Bit index is 3 bits, counting 0..7.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** counter held at 0. `rx_s`==0 → START.
  - **START:** when counter reaches CLKS_PER_BIT/2−1 (integer divide), sample `rx_s`.
    - 0 → DATA, counter cleared, bit index 0.
    - 1 → IDLE (glitch rejected; no output).
  - **DATA:** each time counter reaches CLKS_PER_BIT−1, sample `rx_s` into shift register bit [index], LSB first.
    - Index 7 sampled → STOP.
  - **STOP:** counter reaches CLKS_PER_BIT−1, sample `rx_s`.
    - 1 → load `o_rx_byte` from the shift register, pulse `o_rx_byte_rdy`, go to IDLE.
    - 0 → pulse `o_frame_err`; `o_rx_byte` unchanged; go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- **Reset values:**
  - `o_rx_byte_rdy`=0, `o_rx_byte`=8'h00, `o_frame_err`=0, `o_busy`=0.
  - State IDLE; counters and shift register 0.
- **Reset mid-frame:** the partial frame is discarded, with no strobe. Reception restarts on the next falling edge after reset is released.
- `o_rx_byte_rdy` and `o_frame_err` are never high in the same cycle.

## Timing
- The sample point of every bit is mid-bit, relative to when the synchronized falling edge is detected.
- Synchronizer adds 2 cycles of latency from `i_rx` to `rx_s`.
- Nominal `o_rx_byte_rdy` timing, measured from the `i_rx` falling edge: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (+1 register) cycles, i.e. just after the middle of the stop bit.
- Strobes are registered outputs, exactly 1 cycle wide.
- `o_rx_byte` changes only in the same cycle that `o_rx_byte_rdy` rises.
- **Back-to-back frames:** IDLE is re-entered at mid-stop. A start bit that begins half a bit later (stop-bit end) is detected with no lost frame.
- No backpressure: the downstream stage must consume the byte within one frame time (10·CLKS_PER_BIT cycles).
- Tolerated baud mismatch is roughly ±4% total.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined:** the frame carries an even-parity bit between bit 7 and the stop bit. The FSM gains state PARITY, sampled at counter CLKS_PER_BIT−1.
    - Adds output `o_parity_err` (1 bit, reset 0). It pulses in the same cycle as `o_rx_byte_rdy` when the XOR of the 8 data bits and the parity bit is 1.
    - The byte is still delivered when `o_parity_err` is set.
    - Latency grows by CLKS_PER_BIT.
  - **Undefined:** plain 8N1 as described above; the port `o_parity_err` does not exist.

## Test plan
- CLKS_PER_BIT=8; send 0xA5 as 8N1 → exactly one `o_rx_byte_rdy` pulse, `o_rx_byte`=8'hA5, `o_frame_err`=0, `o_busy` low afterwards.
- Drive a 2-cycle low glitch on `i_rx` while idle → no strobes, state returns to IDLE, `o_rx_byte` stays 8'h00.
- Send 0x3C with the stop bit forced low, hold the line low for 20 bit times, then release → one `o_frame_err` pulse, no `o_rx_byte_rdy`, `o_rx_byte` unchanged. Next valid frame 0x11 → `o_rx_byte`=8'h11.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three `o_rx_byte_rdy` pulses, in order, with the correct values.
- Assert `i_rst_n`=0 during bit 4 of frame 0x77, release it, then send 0x81 → outputs 0 during reset, no strobe for the partial frame, and the next strobe carries 8'h81.
- With `UART_RX_PARITY_EN` defined: send 0x07 with parity bit 1 → `o_parity_err`=0. Send 0x07 with parity bit 0 → `o_parity_err` pulses with `o_rx_byte_rdy`, `o_rx_byte`=8'h07.

Source files
------------

// File: rtl/uart_rx_8n1_if.sv
// Receive-side output bundle of uart_rx_8n1: byte, strobes and busy flag.
// o_parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_8n1_if;
  logic       o_rx_byte_rdy;
  logic [7:0] o_rx_byte;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  modport master (
    output o_rx_byte_rdy,
    output o_rx_byte,
    output o_frame_err,
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_busy
  );

  modport slave (
    input o_rx_byte_rdy,
    input o_rx_byte,
    input o_frame_err,
`ifdef UART_RX_PARITY_EN
    input o_parity_err,
`endif
    input o_busy
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, oversampled by i_clk, with mid-bit sampling and framing-error detect.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and o_parity_err.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx,
  uart_rx_8n1_if.master rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StWaitIdle
  } state_e;

  logic            r_rx_meta, r_rx_s;
  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic [7:0]      r_byte, w_byte_d;
  logic            r_rdy, w_rdy_d;
  logic            r_ferr, w_ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            r_par, w_par_d;
  logic            r_perr, w_perr_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_shift   <= w_shift_d;
      r_byte    <= w_byte_d;
      r_rdy     <= w_rdy_d;
      r_ferr    <= w_ferr_d;
`ifdef UART_RX_PARITY_EN
      r_par     <= w_par_d;
      r_perr    <= w_perr_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + CntW'(1);
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_byte_d  = r_byte;
    w_rdy_d   = 1'b0;
    w_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_d   = r_par;
    w_perr_d  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (!r_rx_s) w_state_d = StStart;
      end
      StStart: begin
        // Re-check the line half a bit in so short glitches do not start a frame.
        if (r_cnt == CntHalf) begin
          w_cnt_d   = '0;
          w_idx_d   = '0;
          w_state_d = r_rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (r_cnt == CntLast) begin
          w_cnt_d          = '0;
          w_shift_d[r_idx] = r_rx_s;
          w_idx_d          = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (r_idx == 3'd7) w_state_d = StParity;
`else
          if (r_idx == 3'd7) w_state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_par_d   = r_rx_s;
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (r_cnt == CntLast) begin
          w_cnt_d = '0;
          if (r_rx_s) begin
            w_byte_d  = r_shift;
            w_rdy_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_d  = ^{r_shift, r_par};
`endif
            w_state_d = StIdle;
          end else begin
            w_ferr_d  = 1'b1;
            w_state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        // Hold off until the line returns high so a break is not decoded as 0x00 frames.
        w_cnt_d = '0;
        if (r_rx_s) w_state_d = StIdle;
      end
      default: begin
        w_cnt_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  assign rx_if.o_rx_byte_rdy = r_rdy;
  assign rx_if.o_rx_byte     = r_byte;
  assign rx_if.o_frame_err   = r_ferr;
  assign rx_if.o_busy        = (r_state != StIdle);
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err  = r_perr;
`endif

endmodule
